reorder_buffer: RTL and testbench

Circular reorder buffer between dispatch and the write_results_control commit stage. Allocates one entry per issued instruction and captures results broadcast on the CDB by tag. Presents the oldest entry to commit once that entry is complete. Discards all contents on a branch-mispredict flush.

---
 rtl/reorder_buffer_pkg.sv | 45 ++++
 rtl/reorder_buffer_rob_ptr.sv | 34 +++
 rtl/reorder_buffer.sv | 170 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : lc3b_types                                              |
// | Purpose : Shared LC-3b types used by the reorder buffer: opcode   |
// |           enum, register index, ROB tag and a packed ROB entry    |
// |           layout for the default 16-bit datapath.                 |
// | Ports   : none (package)                                          |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [2:0]  lc3b_rob_tag;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef struct packed {
    logic       valid;
    logic       ready;
    lc3b_opcode opcode;
    lc3b_reg    dest;
    lc3b_word   value;
    logic       predict;
  } lc3b_rob_entry;

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_rob_ptr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : rob_ptr                                                 |
// | Purpose : Wrap-around pointer (modulo 2**tag_width) used for the  |
// |           ROB head and tail.                                      |
// | Ports   : clk, reset (sync, active high)                          |
// |           inc  - advance pointer by one                           |
// |           clr  - return pointer to zero (wins over inc)           |
// |           ptr  - current pointer value                            |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module rob_ptr #(
  parameter int tag_width = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clr,
  output logic [tag_width-1:0] ptr
);

  localparam logic [tag_width-1:0] c_one = tag_width'(1);

  // Natural binary overflow gives the 7 -> 0 wrap with no bubble.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + c_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : reorder_buffer                                          |
// | Purpose : Circular reorder buffer. Allocates at the tail, captures|
// |           CDB results by tag, presents the oldest completed entry |
// |           to commit and discards everything on flush.             |
// | Ports   : clk, reset (sync, active high)                          |
// |           WE/opcode_in/dest_in/predict_in/alloc_ready/alloc_value |
// |             - allocation; alloc_tag, rob_full returned            |
// |           cdb_valid/cdb_tag/cdb_value - result broadcast          |
// |           rd_tag_*/rd_ready_*/rd_value_* - operand lookups        |
// |           valid_out/opcode_out/dest_out/value_out/predict_out     |
// |             - head entry; RE retires it; rob_empty                |
// |           flush - discard all entries                             |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module reorder_buffer
  import lc3b_types::*;
#(
  parameter int data_width = 16,
  parameter int tag_width  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  WE,
  input  lc3b_opcode            opcode_in,
  input  lc3b_reg               dest_in,
  input  logic                  predict_in,
  input  logic                  alloc_ready,
  input  logic [data_width-1:0] alloc_value,
  output logic [tag_width-1:0]  alloc_tag,
  output logic                  rob_full,
  input  logic                  cdb_valid,
  input  logic [tag_width-1:0]  cdb_tag,
  input  logic [data_width-1:0] cdb_value,
  input  logic [tag_width-1:0]  rd_tag_a,
  input  logic [tag_width-1:0]  rd_tag_b,
  output logic                  rd_ready_a,
  output logic                  rd_ready_b,
  output logic [data_width-1:0] rd_value_a,
  output logic [data_width-1:0] rd_value_b,
  output logic                  valid_out,
  output lc3b_opcode            opcode_out,
  output lc3b_reg               dest_out,
  output logic [data_width-1:0] value_out,
  output logic                  predict_out,
  output logic                  rob_empty,
  input  logic                  RE,
  input  logic                  flush
);

  localparam int                 depth     = 2**tag_width;
  localparam logic [tag_width:0] c_depth   = (tag_width+1)'(depth);
  localparam logic [tag_width:0] c_cnt_one = (tag_width+1)'(1);

  // Entry fields kept as parallel arrays so data_width stays generic.
  logic                  valid_q   [depth];
  logic                  ready_q   [depth];
  lc3b_opcode            opcode_q  [depth];
  lc3b_reg               dest_q    [depth];
  logic [data_width-1:0] value_q   [depth];
  logic                  predict_q [depth];

  logic [tag_width-1:0] head;
  logic [tag_width-1:0] tail;
  logic [tag_width:0]   count;
  logic                 alloc;
  logic                 pop;

  assign rob_full  = (count == c_depth);
  assign rob_empty = (count == '0);
  assign alloc_tag = tail;

  assign valid_out   = valid_q[head] && ready_q[head];
  assign opcode_out  = opcode_q[head];
  assign dest_out    = dest_q[head];
  assign value_out   = value_q[head];
  assign predict_out = predict_q[head];

  // rob_full comes from registered count, so a same-cycle pop cannot
  // make room for a WE.
  assign alloc = WE && !rob_full && !flush;
  assign pop   = RE && valid_out && !flush;

  rob_ptr #(.tag_width(tag_width)) u_head (
    .clk   (clk),
    .reset (reset),
    .inc   (pop),
    .clr   (flush),
    .ptr   (head)
  );

  rob_ptr #(.tag_width(tag_width)) u_tail (
    .clk   (clk),
    .reset (reset),
    .inc   (alloc),
    .clr   (flush),
    .ptr   (tail)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else begin
      case ({alloc, pop})
        2'b10:   count <= count + c_cnt_one;
        2'b01:   count <= count - c_cnt_one;
        default: count <= count;
      endcase
    end
  end

  // CDB capture cannot collide with allocation: the tail entry is
  // always invalid whenever alloc is possible. Likewise pop and alloc
  // only share an index when full, where alloc is blocked.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) begin
        valid_q[i]   <= 1'b0;
        ready_q[i]   <= 1'b0;
        opcode_q[i]  <= op_br;
        dest_q[i]    <= '0;
        value_q[i]   <= '0;
        predict_q[i] <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < depth; i++) begin
        valid_q[i] <= 1'b0;
        ready_q[i] <= 1'b0;
      end
    end else begin
      if (cdb_valid && valid_q[cdb_tag] && !ready_q[cdb_tag]) begin
        value_q[cdb_tag] <= cdb_value;
        ready_q[cdb_tag] <= 1'b1;
      end
      if (alloc) begin
        valid_q[tail]   <= 1'b1;
        ready_q[tail]   <= alloc_ready;
        value_q[tail]   <= alloc_value;
        opcode_q[tail]  <= opcode_in;
        dest_q[tail]    <= dest_in;
        predict_q[tail] <= predict_in;
      end
      if (pop) begin
        valid_q[head] <= 1'b0;
      end
    end
  end

  // Operand lookups bypass a same-cycle CDB broadcast to the tag.
  always_comb begin
    rd_ready_a = valid_q[rd_tag_a] && ready_q[rd_tag_a];
    rd_value_a = value_q[rd_tag_a];
    if (cdb_valid && (cdb_tag == rd_tag_a)) begin
      rd_ready_a = 1'b1;
      rd_value_a = cdb_value;
    end
  end

  always_comb begin
    rd_ready_b = valid_q[rd_tag_b] && ready_q[rd_tag_b];
    rd_value_b = value_q[rd_tag_b];
    if (cdb_valid && (cdb_tag == rd_tag_b)) begin
      rd_ready_b = 1'b1;
      rd_value_b = cdb_value;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_reorder_buffer                                       |
// | Purpose : Directed scoreboard bench for reorder_buffer. Expected  |
// |           commits are queued at allocation and popped by a        |
// |           monitor whenever the DUT retires its head.              |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_reorder_buffer;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  lc3b_opcode  opcode_in;
  lc3b_reg     dest_in;
  logic        predict_in;
  logic        alloc_ready;
  logic [15:0] alloc_value;
  logic [2:0]  alloc_tag;
  logic        rob_full;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_value;
  logic [2:0]  rd_tag_a;
  logic [2:0]  rd_tag_b;
  logic        rd_ready_a;
  logic        rd_ready_b;
  logic [15:0] rd_value_a;
  logic [15:0] rd_value_b;
  logic        valid_out;
  lc3b_opcode  opcode_out;
  lc3b_reg     dest_out;
  logic [15:0] value_out;
  logic        predict_out;
  logic        rob_empty;
  logic        RE;
  logic        flush;

  typedef struct {
    lc3b_opcode  op;
    lc3b_reg     dest;
    logic [15:0] val;
    logic        pred;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.data_width(16), .tag_width(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .WE          (WE),
    .opcode_in   (opcode_in),
    .dest_in     (dest_in),
    .predict_in  (predict_in),
    .alloc_ready (alloc_ready),
    .alloc_value (alloc_value),
    .alloc_tag   (alloc_tag),
    .rob_full    (rob_full),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_value   (cdb_value),
    .rd_tag_a    (rd_tag_a),
    .rd_tag_b    (rd_tag_b),
    .rd_ready_a  (rd_ready_a),
    .rd_ready_b  (rd_ready_b),
    .rd_value_a  (rd_value_a),
    .rd_value_b  (rd_value_b),
    .valid_out   (valid_out),
    .opcode_out  (opcode_out),
    .dest_out    (dest_out),
    .value_out   (value_out),
    .predict_out (predict_out),
    .rob_empty   (rob_empty),
    .RE          (RE),
    .flush       (flush)
  );

  // Commit monitor: a retire happens at the next edge whenever RE meets
  // a valid head and no flush; compare it against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && RE && valid_out && !flush) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL commit_unexpected: got op=%h dest=%h val=%h pred=%b, required none",
                 opcode_out, dest_out, value_out, predict_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({opcode_out, dest_out, value_out, predict_out} !== {e.op, e.dest, e.val, e.pred}) begin
          miscompares++;
          $display("FAIL commit: got op=%h dest=%h val=%h pred=%b, required op=%h dest=%h val=%h pred=%b",
                   opcode_out, dest_out, value_out, predict_out, e.op, e.dest, e.val, e.pred);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    WE = 1'b0; RE = 1'b0; flush = 1'b0; cdb_valid = 1'b0;
    alloc_ready = 1'b0; predict_in = 1'b0;
  endtask

  // One clock: inputs seen at the edge, then pulses drop 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic alloc(input lc3b_opcode op, input lc3b_reg d, input logic rdy,
                       input logic [15:0] v, input logic p, input logic expect_commit);
    WE = 1'b1; opcode_in = op; dest_in = d; alloc_ready = rdy;
    alloc_value = v; predict_in = p;
    if (expect_commit) exp_q.push_back('{op, d, v, p});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!rob_empty && n < 12) begin
      RE = 1'b1;
      step();
      n++;
    end
    check({name, "_drained"}, {31'd0, rob_empty}, 32'd1);
  endtask

  lc3b_opcode  ops  [8] = '{op_add, op_and, op_not, op_ldr, op_shf, op_lea, op_add, op_and};
  logic [15:0] vals [8] = '{16'h00a0, 16'h01a1, 16'h02a2, 16'h03a3,
                            16'h04a4, 16'h05a5, 16'h06a6, 16'h07a7};
  int          cdb_order [8] = '{5, 2, 0, 7, 1, 3, 6, 4};

  initial begin
    reset = 1'b1;
    idle_inputs();
    opcode_in = op_add; dest_in = '0; alloc_value = '0;
    cdb_tag = '0; cdb_value = '0; rd_tag_a = '0; rd_tag_b = '0;
    step(); step();
    reset = 1'b0;
    step();

    // Reset state
    check("reset_empty",     {31'd0, rob_empty}, 32'd1);
    check("reset_full",      {31'd0, rob_full},  32'd0);
    check("reset_valid_out", {31'd0, valid_out}, 32'd0);
    check("reset_alloc_tag", {29'd0, alloc_tag}, 32'd0);
    check("reset_rd_ready",  {31'd0, rd_ready_a}, 32'd0);

    // Single add R3, completed over the CDB, then committed
    alloc(op_add, 3'd3, 1'b0, 16'h0000, 1'b0, 1'b0);
    exp_q.push_back('{op_add, 3'd3, 16'h0042, 1'b0});
    step();
    check("add_alloc_tag", {29'd0, alloc_tag}, 32'd1);
    check("add_not_ready", {31'd0, valid_out}, 32'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 16'h0042;
    step();
    check("add_valid_out", {31'd0, valid_out}, 32'd1);
    check("add_dest_out",  {29'd0, dest_out},  32'd3);
    check("add_value_out", {16'd0, value_out}, 32'h0042);
    RE = 1'b1;
    step();
    check("add_empty", {31'd0, rob_empty}, 32'd1);

    // Flush on an empty buffer re-zeroes the pointers
    flush = 1'b1;
    step();
    check("flush_tail_zero", {29'd0, alloc_tag}, 32'd0);

    // Fill all 8 entries, pending
    for (int i = 0; i < 8; i++) begin
      alloc(ops[i], 3'(i), 1'b0, 16'hffff, i[0], 1'b0);
      exp_q.push_back('{ops[i], 3'(i), vals[i], i[0]});
      step();
    end
    check("fill_full",      {31'd0, rob_full},  32'd1);
    check("fill_alloc_tag", {29'd0, alloc_tag}, 32'd0);
    // Ninth WE while full is dropped
    alloc(op_trap, 3'd7, 1'b1, 16'hdead, 1'b1, 1'b0);
    step();
    check("ninth_full",      {31'd0, rob_full},  32'd1);
    check("ninth_alloc_tag", {29'd0, alloc_tag}, 32'd0);
    check("ninth_not_ready", {31'd0, valid_out}, 32'd0);

    // Out-of-order completion
    for (int k = 0; k < 8; k++) begin
      cdb_valid = 1'b1; cdb_tag = 3'(cdb_order[k]); cdb_value = vals[cdb_order[k]];
      step();
    end
    check("ooo_head_ready", {31'd0, valid_out}, 32'd1);

    // Full + pop + WE: pop happens, WE rejected, count becomes 7
    RE = 1'b1;
    alloc(op_stb, 3'd6, 1'b1, 16'hbeef, 1'b0, 1'b0);
    step();
    check("fullpop_not_full", {31'd0, rob_full},  32'd0);
    check("fullpop_not_empty",{31'd0, rob_empty}, 32'd0);
    check("fullpop_alloc_tag",{29'd0, alloc_tag}, 32'd0);
    drain("ooo");
    check("wrap_alloc_tag", {29'd0, alloc_tag}, 32'd0);
    check("wrap_valid_out", {31'd0, valid_out}, 32'd0);

    // Branch with a known alternate PC, then flush at commit
    alloc(op_br, 3'b010, 1'b1, 16'h3000, 1'b0, 1'b0);
    step();
    check("br_valid_out",   {31'd0, valid_out},   32'd1);
    check("br_opcode_out",  {28'd0, opcode_out},  {28'd0, op_br});
    check("br_value_out",   {16'd0, value_out},   32'h3000);
    check("br_predict_out", {31'd0, predict_out}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      alloc(op_add, 3'(i + 1), 1'b0, 16'h0000, 1'b0, 1'b0);
      step();
    end
    check("br_alloc_tag", {29'd0, alloc_tag}, 32'd4);
    flush = 1'b1; RE = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_value = 16'h7777;
    alloc(op_and, 3'd5, 1'b1, 16'h1234, 1'b0, 1'b0);
    step();
    check("flush_empty",     {31'd0, rob_empty}, 32'd1);
    check("flush_full",      {31'd0, rob_full},  32'd0);
    check("flush_alloc_tag", {29'd0, alloc_tag}, 32'd0);
    check("flush_valid_out", {31'd0, valid_out}, 32'd0);
    rd_tag_a = 3'd1;
    #1;
    check("flush_cdb_lost", {31'd0, rd_ready_a}, 32'd0);

    // Read-port bypass
    alloc(op_add, 3'd1, 1'b0, 16'h0000, 1'b0, 1'b0);
    exp_q.push_back('{op_add, 3'd1, 16'h1111, 1'b0});
    step();
    alloc(op_add, 3'd2, 1'b0, 16'h0000, 1'b0, 1'b0);
    exp_q.push_back('{op_add, 3'd2, 16'h2222, 1'b0});
    step();
    alloc(op_add, 3'd3, 1'b0, 16'h0000, 1'b0, 1'b0);
    exp_q.push_back('{op_add, 3'd3, 16'h5a5a, 1'b0});
    step();
    check("byp_alloc_tag", {29'd0, alloc_tag}, 32'd3);
    rd_tag_a = 3'd2; rd_tag_b = 3'd1;
    #1;
    check("byp_pending", {31'd0, rd_ready_a}, 32'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_value = 16'h5a5a;
    #1;
    check("byp_ready", {31'd0, rd_ready_a}, 32'd1);
    check("byp_value", {16'd0, rd_value_a}, 32'h5a5a);
    check("byp_other_port", {31'd0, rd_ready_b}, 32'd0);
    step();
    check("byp_stored_ready", {31'd0, rd_ready_a}, 32'd1);
    check("byp_stored_value", {16'd0, rd_value_a}, 32'h5a5a);
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 16'h1111;
    step();
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_value = 16'h2222;
    step();
    // Repeat CDB to an already-ready entry must not overwrite it
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_value = 16'h9999;
    step();
    drain("byp");

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
